// File: rtl/mem_responder.sv
// Word-addressed backing memory with a fixed access latency, one request
// outstanding at a time, valid/ready on both request and response channels.
module mem_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_wr,
  output logic [31:0] resp_data
);

  localparam int AW = $clog2(DEPTH);
  // BUSY is entered one edge after acceptance and leaves on the edge where the
  // counter reads zero, so loading LATENCY-2 gives exactly LATENCY cycles.
  localparam logic [7:0] LOAD = 8'(LATENCY > 1 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [31:0] mem_r [DEPTH];

  logic [AW-1:0] idx_s;
  logic          accept_s;
  logic          unused_s;

  assign idx_s    = req_addr[AW+1:2];
  assign accept_s = req_valid && req_ready;
  assign unused_s = ^{req_addr[31:AW+2], req_addr[1:0]};

  // Storage keeps its contents across reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s && req_wr) begin
      mem_r[idx_s] <= req_data;
    end
  end

  // Request/response sequencing with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_data  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_ready <= 1'b0;
            resp_wr   <= req_wr;
            resp_data <= req_wr ? 32'd0 : mem_r[idx_s];
            if (LATENCY == 1) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
            end else begin
              cnt_r   <= LOAD;
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_r == 8'd0) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r    <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_data  <= 32'd0;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 8'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_wr    <= 1'b0;
          resp_data  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for the main
// sequence and a LATENCY=1 instance for back-to-back throughput.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_data;
  logic        resp_valid, resp_ready, resp_wr;
  logic [31:0] resp_data;

  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [31:0] b_req_addr, b_req_data;
  logic        b_resp_valid, b_resp_ready, b_resp_wr;
  logic [31:0] b_resp_data;

  int errors = 0;
  int checks = 0;

  mem_responder #(.DEPTH(16), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_wr(resp_wr), .resp_data(resp_data)
  );

  mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_data(b_req_data),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_wr(b_resp_wr), .resp_data(b_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=4 instance with resp_ready high.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp);
    int lat;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, " accepted"}, {31'd0, req_ready}, 32'd0);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " resp_wr"}, {31'd0, resp_wr}, {31'd0, wr});
    chk({tag, " resp_data"}, resp_data, exp);
    @(posedge clk); #1;
    chk({tag, " done valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " done ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_000C; req_data = 32'hBAD0_BAD0;
    resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = 32'd0; b_req_data = 32'd0;
    b_resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_wr", {31'd0, resp_wr}, 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;

    txn("wr 08", 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'd0);
    txn("rd 08", 1'b0, 32'h0000_0008, 32'd0, 32'hDEAD_BEEF);
    txn("wr 04", 1'b1, 32'h0000_0004, 32'h1234_5678, 32'd0);
    txn("rd 47 alias", 1'b0, 32'h0000_0047, 32'd0, 32'h1234_5678);
    txn("rd high bits", 1'b0, 32'hFFFF_FF08, 32'd0, 32'hDEAD_BEEF);
    txn("wr 0C", 1'b1, 32'h0000_000C, 32'h1111_1111, 32'd0);

    // Backpressure: the response must sit still until resp_ready rises.
    resp_ready = 1'b0;
    req_wr = 1'b0; req_addr = 32'h0000_0008; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp resp_data", resp_data, 32'hDEAD_BEEF);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", {31'd0, resp_valid}, 32'd0);
    chk("bp release ready", {31'd0, req_ready}, 32'd1);

    // Reset in cycle 2 of a read drops it; a write attempted under reset is ignored.
    req_wr = 1'b0; req_addr = 32'h0000_0008; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_000C; req_data = 32'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midrst no resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("midrst req_ready", {31'd0, req_ready}, 32'd1);
    txn("rd 0C after rst", 1'b0, 32'h0000_000C, 32'd0, 32'h1111_1111);

    // LATENCY=1 instance: preload three words.
    for (int i = 0; i < 3; i++) begin
      b_req_valid = 1'b1; b_req_wr = 1'b1;
      b_req_addr = 32'(i * 4); b_req_data = 32'hC0DE_0000 + 32'(i);
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      chk("l1 wr ack", {31'd0, b_resp_valid}, 32'd1);
      chk("l1 wr ack wr", {31'd0, b_resp_wr}, 32'd1);
      @(posedge clk); #1;
      chk("l1 wr done", {31'd0, b_req_ready}, 32'd1);
    end

    // Three reads with req_valid held high: accept on every second edge.
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 1) begin
        chk("l1 rd valid", {31'd0, b_resp_valid}, 32'd1);
        chk("l1 rd data", b_resp_data, 32'hC0DE_0000 + 32'((k - 1) / 2));
        chk("l1 rd busy", {31'd0, b_req_ready}, 32'd0);
      end else begin
        chk("l1 rd gap valid", {31'd0, b_resp_valid}, 32'd0);
        chk("l1 rd gap ready", {31'd0, b_req_ready}, 32'd1);
        b_req_addr = 32'((k / 2) * 4);
      end
    end
    b_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
